// File: rtl/leaky_integrator_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | leaky_integrator_mc: time-multiplexed multi-channel leaky integrator with   |
// | per-channel prime-on-first-sample and a sequenced clear-all sweep.          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module leaky_integrator_mc #(
  parameter int WI         = 8,
  parameter int WF         = 32,
  parameter int NCH        = 4,
  parameter int KW         = 6,
  parameter bit PRIME_LOAD = 1'b1,
  localparam int W         = WI + WF,
  localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                Clk,
  input  logic                Rstn,
  input  logic signed [W-1:0] InLeaky,
  input  logic [CW-1:0]       InChan,
  input  logic                LIdvi,
  input  logic [KW-1:0]       LeakShift,
  input  logic                ClearAll,
  output logic signed [W-1:0] OutSmooth,
  output logic [CW-1:0]       OutChan,
  output logic                LIdvo,
  output logic                Busy
);

  localparam logic [CW:0]   c_NCH_EXT = (CW+1)'(NCH);
  localparam logic [CW-1:0] c_LAST_CH = CW'(NCH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t              r_fsm;
  state_t              w_fsm_nxt;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;

  logic                r_v1;
  logic signed [W-1:0] r_x;
  logic [CW-1:0]       r_ch;
  logic [KW-1:0]       r_k;

  logic signed [W-1:0] r_state [NCH];
  logic [NCH-1:0]      r_primed;

  logic                w_accept;
  logic signed [W-1:0] w_y;
  logic signed [W:0]   w_d;
  logic signed [W:0]   w_s;
  logic signed [W:0]   w_sum;
  logic signed [W-1:0] w_ynew;
  logic                w_unused;
  logic [NCH-1:0]      w_wr_sel;
  logic [NCH-1:0]      w_clr_sel;

  assign w_accept = LIdvi && (r_fsm == S_IDLE) && !ClearAll &&
                    ({1'b0, InChan} < c_NCH_EXT);

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE:  if (ClearAll) w_fsm_nxt = S_CLEAR;
      S_CLEAR: if (r_cnt == c_LAST_CH) w_fsm_nxt = S_IDLE;
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      r_fsm  <= S_IDLE;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else begin
      r_fsm  <= w_fsm_nxt;
      r_busy <= (w_fsm_nxt == S_CLEAR);
      r_cnt  <= (r_fsm == S_CLEAR) ? r_cnt + 1'b1 : '0;
    end
  end

  assign Busy = r_busy;

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      r_v1 <= 1'b0;
      r_x  <= '0;
      r_ch <= '0;
      r_k  <= '0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_x  <= InLeaky;
        r_ch <= InChan;
        r_k  <= LeakShift;
      end
    end
  end

  // y' stays between y and x, so dropping the extra sum bit never loses data
  assign w_y      = r_state[r_ch];
  assign w_d      = {r_x[W-1], r_x} - {w_y[W-1], w_y};
  assign w_s      = w_d >>> r_k;
  assign w_sum    = {w_y[W-1], w_y} + w_s;
  assign w_unused = w_sum[W];
  assign w_ynew   = (PRIME_LOAD && !r_primed[r_ch]) ? r_x : w_sum[W-1:0];

  for (genvar c = 0; c < NCH; c++) begin : g_sel
    assign w_wr_sel[c]  = r_v1 && (r_ch == CW'(c));
    assign w_clr_sel[c] = (r_fsm == S_CLEAR) && (r_cnt == CW'(c));
  end

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      for (int c = 0; c < NCH; c++) begin
        r_state[c]  <= '0;
        r_primed[c] <= 1'b0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (w_clr_sel[c]) begin
          r_state[c]  <= '0;
          r_primed[c] <= 1'b0;
        end else if (w_wr_sel[c]) begin
          r_state[c]  <= w_ynew;
          r_primed[c] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      OutSmooth <= '0;
      OutChan   <= '0;
      LIdvo     <= 1'b0;
    end else begin
      LIdvo <= r_v1;
      if (r_v1) begin
        OutSmooth <= w_ynew;
        OutChan   <= r_ch;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_leaky_integrator_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_leaky_integrator_mc: directed self-checking bench, NCH=4 and NCH=3.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_leaky_integrator_mc;

  localparam logic [39:0] c_ONE   = 40'h01_00000000;
  localparam logic [39:0] c_MONE  = 40'hFF_00000000;
  localparam logic [39:0] c_LSBN  = 40'hFF_FFFFFFFF;
  localparam logic [39:0] c_MIN   = 40'h80_00000000;
  localparam logic [39:0] c_MAX   = 40'h7F_FFFFFFFF;

  logic        Clk = 1'b0;
  logic        Rstn;
  logic [39:0] InLeaky;
  logic [1:0]  InChan;
  logic        LIdvi;
  logic [5:0]  LeakShift;
  logic        ClearAll;
  logic [39:0] OutSmooth, OutSmooth3;
  logic [1:0]  OutChan, OutChan3;
  logic        LIdvo, LIdvo3, Busy, Busy3;

  int n_chk  = 0;
  int n_fail = 0;
  int busy_n = 0;

  always #5 Clk = ~Clk;

  leaky_integrator_mc #(.WI(8), .WF(32), .NCH(4), .KW(6), .PRIME_LOAD(1'b1)) dut (
    .Clk(Clk), .Rstn(Rstn), .InLeaky(InLeaky), .InChan(InChan), .LIdvi(LIdvi),
    .LeakShift(LeakShift), .ClearAll(ClearAll), .OutSmooth(OutSmooth),
    .OutChan(OutChan), .LIdvo(LIdvo), .Busy(Busy)
  );

  leaky_integrator_mc #(.WI(8), .WF(32), .NCH(3), .KW(6), .PRIME_LOAD(1'b1)) dut3 (
    .Clk(Clk), .Rstn(Rstn), .InLeaky(InLeaky), .InChan(InChan), .LIdvi(LIdvi),
    .LeakShift(LeakShift), .ClearAll(ClearAll), .OutSmooth(OutSmooth3),
    .OutChan(OutChan3), .LIdvo(LIdvo3), .Busy(Busy3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] ch, input logic [39:0] x,
                       input logic [5:0] k, input logic clr);
    LIdvi     = v;
    InChan    = ch;
    InLeaky   = x;
    LeakShift = k;
    ClearAll  = clr;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [39:0] y, input logic [1:0] ch);
    check({tag, ".v"},   64'(LIdvo), 64'd1);
    check({tag, ".y"},   64'(OutSmooth), 64'(y));
    check({tag, ".ch"},  64'(OutChan), 64'(ch));
  endtask

  initial begin
    Rstn = 1'b0;
    drive(0, 0, '0, '0, 0);
    #12;
    check("rst.y",    64'(OutSmooth), 64'd0);
    check("rst.ch",   64'(OutChan),   64'd0);
    check("rst.v",    64'(LIdvo),     64'd0);
    check("rst.busy", 64'(Busy),      64'd0);
    tick();
    Rstn = 1'b1;

    // step response ch0, K=2
    drive(1, 0, '0, 6'd2, 0);                 tick();
    check("step.lat", 64'(LIdvo), 64'd0);
    drive(1, 0, 40'h04_00000000, 6'd2, 0);    tick(); chk_out("step0", '0, 2'd0);
    drive(1, 0, 40'h04_00000000, 6'd2, 0);    tick(); chk_out("step1", c_ONE, 2'd0);
    drive(1, 0, 40'h04_00000000, 6'd2, 0);    tick(); chk_out("step2", 40'h01_C0000000, 2'd0);
    drive(0, 0, '0, '0, 0);                   tick(); chk_out("step3", 40'h02_50000000, 2'd0);
    tick();
    check("step.idle.v", 64'(LIdvo), 64'd0);
    check("step.hold",   64'(OutSmooth), 64'h02_50000000);

    // interleaved channels, K=1, both primed at 0
    drive(1, 0, '0, 6'd0, 0);                 tick();
    drive(1, 1, '0, 6'd0, 0);                 tick(); chk_out("il.p0", '0, 2'd0);
    drive(1, 0, c_ONE, 6'd1, 0);              tick(); chk_out("il.p1", '0, 2'd1);
    drive(1, 1, c_MONE, 6'd1, 0);             tick(); chk_out("il.a0", 40'h00_80000000, 2'd0);
    drive(1, 0, c_ONE, 6'd1, 0);              tick(); chk_out("il.a1", 40'hFF_80000000, 2'd1);
    drive(1, 1, c_MONE, 6'd1, 0);             tick(); chk_out("il.b0", 40'h00_C0000000, 2'd0);
    drive(0, 0, '0, '0, 0);                   tick(); chk_out("il.b1", 40'hFF_40000000, 2'd1);

    // floor and extremes
    drive(1, 2, '0, 6'd0, 0);                 tick();
    drive(1, 2, c_LSBN, 6'd1, 0);             tick(); chk_out("fl.p", '0, 2'd2);
    drive(1, 3, c_MIN, 6'd0, 0);              tick(); chk_out("fl.floor", c_LSBN, 2'd2);
    drive(1, 3, c_MAX, 6'd0, 0);              tick(); chk_out("ex.prime", c_MIN, 2'd3);
    drive(1, 3, c_MIN, 6'd0, 0);              tick(); chk_out("ex.k0", c_MAX, 2'd3);
    drive(1, 3, c_MAX, 6'd45, 0);             tick(); chk_out("ex.back", c_MIN, 2'd3);

    // clear sweep with LIdvi held on ch2
    drive(1, 2, 40'h03_00000000, 6'd0, 0);    tick(); chk_out("ex.k45", c_MIN, 2'd3);
    drive(1, 2, 40'h03_00000000, 6'd0, 1);    tick(); chk_out("clr.inflight", 40'h03_00000000, 2'd2);
    check("clr.busy.rise", 64'(Busy), 64'd1);
    busy_n = int'(Busy);
    for (int i = 0; i < 5; i++) begin
      drive(1, 2, 40'h03_00000000, 6'd2, (i == 1));
      tick();
      check($sformatf("clr.busy%0d", i), 64'(Busy), (i < 3) ? 64'd1 : 64'd0);
      check($sformatf("clr.nov%0d", i), 64'(LIdvo), 64'd0);
      busy_n += int'(Busy);
    end
    check("clr.busy.len", 64'(busy_n), 64'd4);
    drive(0, 0, '0, '0, 0);                   tick(); chk_out("clr.reprime", 40'h03_00000000, 2'd2);

    // async reset mid-operation
    drive(1, 1, c_ONE, 6'd0, 0);              tick();
    drive(1, 1, c_ONE, 6'd0, 1);              tick(); chk_out("ar.pre", c_ONE, 2'd1);
    check("ar.pre.busy", 64'(Busy), 64'd1);
    #2 Rstn = 1'b0;
    #1;
    check("ar.y",    64'(OutSmooth), 64'd0);
    check("ar.ch",   64'(OutChan),   64'd0);
    check("ar.v",    64'(LIdvo),     64'd0);
    check("ar.busy", 64'(Busy),      64'd0);
    drive(1, 0, c_ONE, 6'd0, 0);
    tick(); tick();
    check("ar.hold.v", 64'(LIdvo), 64'd0);
    check("ar.hold.y", 64'(OutSmooth), 64'd0);
    Rstn = 1'b1;

    // after release: first samples prime; NCH=3 drops InChan=3
    drive(1, 3, 40'h05_00000000, 6'd3, 0);    tick();
    drive(1, 2, 40'h02_00000000, 6'd3, 0);    tick(); chk_out("ar.prime", 40'h05_00000000, 2'd3);
    check("n3.drop.v", 64'(LIdvo3), 64'd0);
    check("n3.drop.y", 64'(OutSmooth3), 64'd0);
    drive(0, 0, '0, '0, 0);                   tick(); chk_out("ar.prime2", 40'h02_00000000, 2'd2);
    check("n3.acc.v",  64'(LIdvo3), 64'd1);
    check("n3.acc.y",  64'(OutSmooth3), 64'h02_00000000);
    check("n3.acc.ch", 64'(OutChan3), 64'd2);
    tick();
    check("n3.idle.v", 64'(LIdvo3), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
